alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle unsigned 64x64 multiplier (low 64 bits of the product).
// The block has no adder or shifter of its own. Each step is issued to the external LEGv8
// ALU through the alu_* ports, and the ALU result is captured on the following edge.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   start, X, Y        request plus multiplicand/multiplier, accepted only in IDLE
//   busy, done         busy outside IDLE; done is a one-cycle pulse when the product is final
//   product, ovf       low 64 bits of X*Y and the overflow flag (true product >= 2^64)
//   alu_A/B/FS/C0      operands, function select and carry-in driven to the ALU
//   alu_F, alu_status  combinational ALU result and its flags {V,C,N,Z}
module alu_mul_sequencer #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] X,
    input  logic [63:0] Y,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic        ovf,
    output logic [63:0] alu_A,
    output logic [63:0] alu_B,
    output logic [4:0]  alu_FS,
    output logic        alu_C0,
    input  logic [63:0] alu_F,
    input  logic [3:0]  alu_status
);

    localparam logic [4:0] FsIdle = 5'b11000;
    localparam logic [4:0] FsAdd  = 5'b01000;
    localparam logic [4:0] FsShl  = 5'b10000;
    localparam logic [4:0] FsShr  = 5'b10100;

    typedef enum logic [2:0] {StIdle, StAdd, StShl, StShr, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        term;

    // Only the carry and zero flags steer the sequence.
    logic unused_status;
    assign unused_status = alu_status[3] ^ alu_status[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        term     = 1'b0;
        done     = 1'b0;
        alu_A    = '0;
        alu_B    = '0;
        alu_FS   = FsIdle;
        alu_C0   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = X;
                    mplier_d = Y;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = Y[0] ? StAdd : StShl;
                end
            end
            StAdd: begin
                alu_A   = acc_q;
                alu_B   = mcand_q;
                alu_FS  = FsAdd;
                acc_d   = alu_F;
                ovf_d   = ovf_q | alu_status[2];
                state_d = StShl;
            end
            StShl: begin
                alu_A   = mcand_q;
                alu_B   = 64'd1;
                alu_FS  = FsShl;
                mcand_d = alu_F;
                // A multiplicand bit shifted out still matters if any higher multiplier
                // bit remains to be added in later.
                ovf_d   = ovf_q | (mcand_q[63] & (|mplier_q[63:1]));
                state_d = StShr;
            end
            StShr: begin
                alu_A    = mplier_q;
                alu_B    = 64'd1;
                alu_FS   = FsShr;
                mplier_d = alu_F;
                cnt_d    = cnt_q + 6'd1;
                term     = EARLY_EXIT ? alu_status[0] : (cnt_q == 6'd63);
                if (term) begin
                    state_d = StDone;
                end else begin
                    state_d = alu_F[0] ? StAdd : StShl;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign product = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: one early-exit instance and one fixed-latency instance, each
// paired with a behavioural LEGv8 ALU. Expected product, overflow and latency are pushed on
// acceptance and compared when done pulses.
module tb_alu_mul_sequencer;

    typedef struct {
        logic [63:0] prod;
        logic        ovf;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        start_e = 1'b0;
    logic        start_f = 1'b0;
    logic [63:0] x_in = '0;
    logic [63:0] y_in = '0;

    logic        busy_e, done_e, ovf_e, c0_e;
    logic [63:0] product_e, a_e, b_e, f_e;
    logic [4:0]  fs_e;
    logic [3:0]  st_e;
    logic        busy_f, done_f, ovf_f, c0_f;
    logic [63:0] product_f, a_f, b_f, f_f;
    logic [4:0]  fs_f;
    logic [3:0]  st_f;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc_e = 0;
    int acc_cyc_f = 0;
    int add_cnt_e = 0;
    int busy_low_e = 0;
    int done_cnt_e = 0;
    logic prev_done_e = 1'b0;
    logic prev_done_f = 1'b0;
    exp_t q_e[$];
    exp_t q_f[$];

    alu_mul_sequencer #(.EARLY_EXIT(1'b1)) u_dut_e (
        .clock(clock), .reset(reset), .start(start_e), .X(x_in), .Y(y_in),
        .busy(busy_e), .done(done_e), .product(product_e), .ovf(ovf_e),
        .alu_A(a_e), .alu_B(b_e), .alu_FS(fs_e), .alu_C0(c0_e),
        .alu_F(f_e), .alu_status(st_e)
    );

    alu_mul_sequencer #(.EARLY_EXIT(1'b0)) u_dut_f (
        .clock(clock), .reset(reset), .start(start_f), .X(x_in), .Y(y_in),
        .busy(busy_f), .done(done_f), .product(product_f), .ovf(ovf_f),
        .alu_A(a_f), .alu_B(b_f), .alu_FS(fs_f), .alu_C0(c0_f),
        .alu_F(f_f), .alu_status(st_f)
    );

    // Behavioural ALU: returns {V,C,N,Z,F}.
    function automatic logic [67:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [4:0] fs, input logic c0);
        logic [63:0] aa, bb, f;
        logic [64:0] s;
        logic        c, v;
        aa = fs[1] ? ~a : a;
        bb = fs[0] ? ~b : b;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (fs[4:2])
            3'd0: f = aa & bb;
            3'd1: f = aa | bb;
            3'd2: begin
                s = {1'b0, aa} + {1'b0, bb} + {64'd0, c0};
                f = s[63:0];
                c = s[64];
                v = (aa[63] == bb[63]) && (f[63] != aa[63]);
            end
            3'd3: f = aa ^ bb;
            3'd4: f = a << b[5:0];
            3'd5: f = a >> b[5:0];
            default: f = '0;
        endcase
        return {v, c, f[63], (f == 64'd0), f};
    endfunction

    always_comb {st_e, f_e} = alu_fn(a_e, b_e, fs_e, c0_e);
    always_comb {st_f, f_f} = alu_fn(a_f, b_f, fs_f, c0_f);

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int calc_lat(input logic [63:0] y, input bit early);
        int k;
        k = 0;
        if (early) begin
            for (int i = 0; i < 64; i++) if (y[i]) k = i;
        end else begin
            k = 63;
        end
        return 2 + 2 * k + $countones(y);
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (fs_e == 5'b01000) add_cnt_e++;
            if (!busy_e && q_e.size() != 0) busy_low_e++;
            if (done_e) begin
                exp_t ex;
                done_cnt_e++;
                check_val("done_single_e", {63'd0, prev_done_e}, 64'd0);
                if (q_e.size() == 0) begin
                    check_val("unexpected_done_e", 64'd1, 64'd0);
                end else begin
                    ex = q_e.pop_front();
                    check_val("product_e", product_e, ex.prod);
                    check_val("ovf_e", {63'd0, ovf_e}, {63'd0, ex.ovf});
                    check_val("latency_e", 64'(cyc - acc_cyc_e), 64'(ex.lat));
                end
            end
        end
        prev_done_e <= done_e;
    end

    always @(negedge clock) begin
        if (!reset && done_f) begin
            exp_t ex;
            check_val("done_single_f", {63'd0, prev_done_f}, 64'd0);
            if (q_f.size() == 0) begin
                check_val("unexpected_done_f", 64'd1, 64'd0);
            end else begin
                ex = q_f.pop_front();
                check_val("product_f", product_f, ex.prod);
                check_val("ovf_f", {63'd0, ovf_f}, {63'd0, ex.ovf});
                check_val("latency_f", 64'(cyc - acc_cyc_f), 64'(ex.lat));
            end
        end
        prev_done_f <= done_f;
    end

    task automatic wait_idle(input bit full);
        int n;
        n = 0;
        @(negedge clock);
        while ((full ? busy_f : busy_e) && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) check_val("idle_timeout", 64'd1, 64'd0);
    endtask

    // Returns 1ns after the accepting edge.
    task automatic start_op(input bit full, input logic [63:0] x, input logic [63:0] y);
        exp_t ex;
        logic [127:0] p;
        wait_idle(full);
        x_in = x;
        y_in = y;
        if (full) start_f = 1'b1;
        else start_e = 1'b1;
        @(posedge clock);
        #1;
        start_e = 1'b0;
        start_f = 1'b0;
        p = {64'd0, x} * {64'd0, y};
        ex.prod = p[63:0];
        ex.ovf  = |p[127:64];
        ex.lat  = calc_lat(y, !full);
        if (full) begin
            acc_cyc_f = cyc;
            q_f.push_back(ex);
        end else begin
            acc_cyc_e = cyc;
            q_e.push_back(ex);
        end
    endtask

    task automatic wait_done(input bit full);
        int n;
        n = 0;
        while ((full ? q_f.size() : q_e.size()) != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if ((full ? q_f.size() : q_e.size()) != 0) begin
            check_val("done_timeout", 64'd1, 64'd0);
            if (full) q_f.delete();
            else q_e.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int snap;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_busy", {63'd0, busy_e}, 64'd0);
        check_val("rst_done", {63'd0, done_e}, 64'd0);
        check_val("rst_product", product_e, 64'd0);
        check_val("rst_ovf", {63'd0, ovf_e}, 64'd0);
        check_val("rst_fs_idle", {59'd0, fs_e}, 64'h18);
        check_val("rst_busy_f", {63'd0, busy_f}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Y=0: SHL, SHR, DONE
        start_op(1'b0, 64'd5, 64'd0);
        check_val("y0_fs_shl", {59'd0, fs_e}, 64'h10);
        @(posedge clock);
        #1;
        check_val("y0_fs_shr", {59'd0, fs_e}, 64'h14);
        @(posedge clock);
        #1;
        check_val("y0_fs_done", {59'd0, fs_e}, 64'h18);
        check_val("y0_done", {63'd0, done_e}, 64'd1);
        wait_done(1'b0);

        // 6*7: three add steps
        add_cnt_e = 0;
        start_op(1'b0, 64'd6, 64'd7);
        wait_done(1'b0);
        check_val("add_cycles", 64'(add_cnt_e), 64'd3);

        // Multiplicand MSB lost on the shift
        start_op(1'b0, 64'h8000_0000_0000_0000, 64'd2);
        wait_done(1'b0);

        // Worst case, busy must never drop
        busy_low_e = 0;
        snap = done_cnt_e;
        start_op(1'b0, '1, '1);
        wait_done(1'b0);
        check_val("ones_busy_low", 64'(busy_low_e), 64'd0);
        check_val("ones_done_pulses", 64'(done_cnt_e - snap), 64'd1);

        // Fixed-latency instance, back to back
        start_op(1'b1, 64'd3, 64'd1);
        wait_done(1'b1);
        start_op(1'b1, 64'd2, 64'd2);
        wait_done(1'b1);

        // Random operands on both instances
        for (int i = 0; i < 4; i++) begin
            logic [63:0] rx, ry;
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom} >> $urandom_range(63, 0);
            start_op(1'b0, rx, ry);
            wait_done(1'b0);
            start_op(1'b1, rx, ry);
            wait_done(1'b1);
        end

        // start while busy and during DONE must be dropped
        start_op(1'b0, 64'd6, 64'd7);
        repeat (3) @(negedge clock);
        x_in = 64'd99;
        y_in = 64'd99;
        start_e = 1'b1;
        @(negedge clock);
        start_e = 1'b0;
        begin
            int n;
            n = 0;
            while (!done_e && n < 400) begin
                @(negedge clock);
                n++;
            end
            check_val("drop_done_seen", {63'd0, done_e}, 64'd1);
        end
        start_e = 1'b1;
        @(negedge clock);
        start_e = 1'b0;
        check_val("drop_busy", {63'd0, busy_e}, 64'd0);
        check_val("drop_product", product_e, 64'd42);
        repeat (3) @(negedge clock);
        check_val("drop_still_idle", {63'd0, busy_e}, 64'd0);

        // Reset during the second ADD (acc already 6)
        start_op(1'b0, 64'd6, 64'd7);
        repeat (3) @(posedge clock);
        #1;
        check_val("mid_add_fs", {59'd0, fs_e}, 64'h08);
        check_val("mid_add_acc", product_e, 64'd6);
        @(negedge clock);
        reset = 1'b1;
        q_e.delete();
        @(posedge clock);
        #1;
        check_val("mid_rst_busy", {63'd0, busy_e}, 64'd0);
        check_val("mid_rst_product", product_e, 64'd0);
        check_val("mid_rst_done", {63'd0, done_e}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        snap = done_cnt_e;
        repeat (200) @(negedge clock);
        check_val("mid_rst_no_done", 64'(done_cnt_e - snap), 64'd0);

        // Recovery after reset
        start_op(1'b0, 64'd3, 64'd5);
        wait_done(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
